seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider; the inverse operation to the team's carry-save array multiplier.
- Computes quotient and remainder of two bitsize-bit unsigned operands, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath. Multiplier-based test loops use it to check products: product / factor1 must equal factor0 with remainder 0.

Parameters:
- bitsize, 8, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a division; sampled only when not busy
- dividend  input  bitsize  unsigned dividend; captured on the accepting edge
- divisor  input  bitsize  unsigned divisor; captured on the accepting edge
- busy  output  1  high while the division iterates
- done  output  1  one-cycle pulse when results become valid
- quotient  output  bitsize  result; held until the next accepted start
- remainder  output  bitsize  result; held until the next accepted start
- div_by_zero  output  1  flag for the last accepted operation; held with the results

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Iteration counter=0 and internal registers cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 (start accepted):
  - Capture dividend into Q shift register, divisor into D, clear partial remainder R (bitsize+1 bits).
  - Load counter=bitsize.
  - If divisor==0, go to DONE; otherwise go to RUN with busy=1.
- Start is ignored while in RUN; the operand inputs are don't-care there.
- RUN, once per edge:
  - T = {R[bitsize-1:0], Q[bitsize-1]} - {1'b0, D}, computed at bitsize+1 bits.
  - If T's MSB is 0: R=T, Q={Q[bitsize-2:0],1}.
  - Otherwise: R={R[bitsize-1:0], Q[bitsize-1]}, Q={Q[bitsize-2:0],0}.
  - Decrement the counter. On the edge where the counter goes 1->0, go to DONE.
- Entering DONE (registered on the same edge):
  - quotient=Q, remainder=R[bitsize-1:0], div_by_zero=0, done=1, busy=0.
- Divide by zero (entering DONE directly from the accepting edge):
  - quotient=all ones, remainder=dividend, div_by_zero=1, done=1.
  - Latency 1 cycle.
- DONE lasts exactly one cycle: done=1.
  - Next edge: with start=1, accept the new operation (back-to-back allowed, no idle gap); otherwise go to IDLE with done=0.
- Latency, nonzero divisor: start accepted at edge E0 -> busy high E0..E0+bitsize -> done high for the cycle after edge E0+bitsize.
  - That is bitsize+1 edges from accept to done.
  - Throughput is one division per bitsize+1 cycles.
- Output stability:
  - quotient, remainder and div_by_zero update only on entering DONE.
  - They do not change during RUN; the previous results stay visible while busy.
- Widths: no overflow is possible.
  - Quotient always fits in bitsize bits.
  - Remainder < divisor whenever the divisor is nonzero.
- Invariant on every done with div_by_zero=0: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Reset, then start with dividend=200, divisor=7 -> busy for 8 cycles; done pulse on the 9th edge after accept; quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=77, divisor=0 -> done one cycle after accept with busy never high; quotient=255, remainder=77, div_by_zero=1. A following 100/10 -> quotient=10, remainder=0, div_by_zero=0.
- Start 200/7; pulse start with 9/3 at cycle 3 of RUN -> the second request is ignored and results are 28 r 4. Assert start with 9/3 during the done cycle -> accepted back-to-back; result 3 r 0 after 9 more edges.
- Start 200/7; assert rst at cycle 4 of RUN -> all outputs 0 immediately (asynchronous); no done pulse. A new 50/6 after release -> 8 r 2.
- Random sweep, bitsize=8, 2000 pairs including divisor=0 and 255/255 -> each done satisfies the invariant.
  - Cross-check: feed products from the multiplier model (factor0*factor1, bitsize=4 operands, instance bitsize=8), divide by nonzero factor1 -> quotient=factor0, remainder=0.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; last results held
//   RUN   | shifting/subtracting, one quotient bit per edge
//   DONE  | one-cycle done pulse; a new start may be accepted here
module seq_restoring_divider #(
    parameter int bitsize = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [bitsize-1:0] dividend,
    input  logic [bitsize-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [bitsize-1:0] quotient,
    output logic [bitsize-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CW = $clog2(bitsize + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [bitsize-1:0] q_reg, d_reg;
    // Partial remainder is always below the divisor, so its top bit is never stored.
    logic [bitsize-1:0] r_reg;
    logic [CW-1:0]      count;
    logic               accept, last;
    logic [bitsize:0]   shifted, trial;
    logic [bitsize-1:0] r_nxt, q_nxt;

    always_comb begin
        accept  = start && (state != RUN);
        last    = (count == CW'(1));
        shifted = {r_reg, q_reg[bitsize-1]};
        trial   = shifted - {1'b0, d_reg};
        if (!trial[bitsize]) begin
            r_nxt = trial[bitsize-1:0];
            q_nxt = {q_reg[bitsize-2:0], 1'b1};
        end else begin
            r_nxt = shifted[bitsize-1:0];
            q_nxt = {q_reg[bitsize-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= CW'(bitsize);
            // Zero divisor skips iteration and publishes the saturated result directly.
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            q_reg <= q_nxt;
            r_reg <= r_nxt;
            count <= count - CW'(1);
            if (last) begin
                quotient    <= q_nxt;
                remainder   <= r_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vector table, handshake
// corner sequences, random sweep and multiplier-product cross-check.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int errors = 0;
    int checks = 0;

    seq_restoring_divider #(.bitsize(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next posedge, returns at the negedge after it.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom_range(0, 255);
        divisor  = $urandom_range(0, 255);
    endtask

    // lat counts edges from the accepting edge to the edge that raised done.
    task automatic wait_done(input int lat0, output int lat, output int busyc);
        lat   = lat0;
        busyc = 0;
        while (!done && lat < 40) begin
            if (busy) busyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, busyc, ndone, a, b;

        vecs[0] = '{"200/7",   8'd200, 8'd7,   8'd28,  8'd4,  1'b0};
        vecs[1] = '{"255/1",   8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
        vecs[2] = '{"5/9",     8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
        vecs[3] = '{"77/0",    8'd77,  8'd0,   8'd255, 8'd77, 1'b1};
        vecs[4] = '{"100/10",  8'd100, 8'd10,  8'd10,  8'd0,  1'b0};
        vecs[5] = '{"255/255", 8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
        vecs[6] = '{"0/5",     8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
        vecs[7] = '{"128/3",   8'd128, 8'd3,   8'd42,  8'd2,  1'b0};
        vecs[8] = '{"0/0",     8'd0,   8'd0,   8'd255, 8'd0,  1'b1};
        vecs[9] = '{"254/16",  8'd254, 8'd16,  8'd15,  8'd14, 1'b0};

        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset dbz", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(1, lat, busyc);
            check({vecs[i].name, " latency"}, lat, (vecs[i].b == 0) ? 1 : 9);
            check({vecs[i].name, " busy cycles"}, busyc, (vecs[i].b == 0) ? 0 : 8);
            check({vecs[i].name, " quotient"}, quotient, vecs[i].q);
            check({vecs[i].name, " remainder"}, remainder, vecs[i].r);
            check({vecs[i].name, " dbz"}, div_by_zero, vecs[i].z);
            @(negedge clk);
            check({vecs[i].name, " done pulse width"}, done, 0);
        end

        // Start during RUN is ignored; start during DONE is accepted back-to-back.
        launch(8'd200, 8'd7);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        check("results held while busy", quotient, 15);
        check("remainder held while busy", remainder, 14);
        wait_done(4, lat, busyc);
        check("ignored start latency", lat, 9);
        check("ignored start quotient", quotient, 28);
        check("ignored start remainder", remainder, 4);
        launch(8'd9, 8'd3);
        check("back-to-back busy", busy, 1);
        check("back-to-back done low", done, 0);
        wait_done(1, lat, busyc);
        check("back-to-back latency", lat, 9);
        check("back-to-back quotient", quotient, 3);
        check("back-to-back remainder", remainder, 0);
        @(negedge clk);

        // Asynchronous reset mid-RUN aborts with no done pulse.
        launch(8'd200, 8'd7);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        check("abort dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no done", ndone, 0);
        launch(8'd50, 8'd6);
        wait_done(1, lat, busyc);
        check("after abort latency", lat, 9);
        check("after abort quotient", quotient, 8);
        check("after abort remainder", remainder, 2);
        @(negedge clk);

        // Random sweep against integer division (zero divisor -> saturated result).
        for (int i = 0; i < 2000; i++) begin
            a = $urandom_range(0, 255);
            b = (i % 50 == 0) ? 0 : (i % 50 == 1) ? 255 : $urandom_range(0, 255);
            if (i % 50 == 1) a = 255;
            launch(a[7:0], b[7:0]);
            wait_done(1, lat, busyc);
            if (b == 0) begin
                check("sweep dbz result", {div_by_zero, quotient, remainder}, {1'b1, 8'd255, a[7:0]});
            end else begin
                check("sweep result", {div_by_zero, quotient, remainder}, {1'b0, a[7:0] / b[7:0], a[7:0] % b[7:0]});
                check("sweep invariant", quotient * b + remainder, a);
            end
            if (i % 3 == 0) @(negedge clk);
        end
        @(negedge clk);

        // Products of 4-bit factors divided by the nonzero factor give the other factor exactly.
        for (int f0 = 0; f0 < 16; f0++) begin
            for (int f1 = 1; f1 < 16; f1++) begin
                launch(8'(f0 * f1), 8'(f1));
                wait_done(1, lat, busyc);
                check("mul cross-check", {div_by_zero, quotient, remainder}, {1'b0, 8'(f0), 8'd0});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
